// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// command byte plus odd parity out on device-generated clock edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_TIMEOUT    = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       iPs2Clk,
  input  logic       iPs2Dat,
  output logic       oClkDriveLow,
  output logic       oDatDriveLow,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int MAX_A = (INHIBIT_CYCLES > REQ_TIMEOUT) ? INHIBIT_CYCLES : REQ_TIMEOUT;
  localparam int MAX_C = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int TW    = $clog2(MAX_C + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_STOP, S_ACK, S_WAIT_IDLE, S_OK, S_FAIL
  } state_t;

  state_t        r_state, w_next;
  logic          r_clk_s1, r_clk_s2, r_clk_d;
  logic          r_dat_s1, r_dat_s2;
  logic [8:0]    r_shift;
  logic [3:0]    r_edge_cnt;
  logic [TW-1:0] r_timer;
  logic          r_dat_low;
  logic          w_fall, w_tc, w_accept;

  assign w_fall   = r_clk_d & ~r_clk_s2;
  assign w_tc     = (r_timer == '0);
  assign w_accept = (r_state == S_IDLE) && iSend;

  // Synchronisers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= iPs2Clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= iPs2Dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    oClkDriveLow = 1'b0;
    oDatDriveLow = 1'b0;
    oBusy        = 1'b1;
    oDone        = 1'b0;
    oError       = 1'b0;
    case (r_state)
      S_IDLE: begin
        oBusy = 1'b0;
        if (iSend) w_next = S_INHIBIT;
      end
      S_INHIBIT: begin
        oClkDriveLow = 1'b1;
        if (w_tc) w_next = S_START;
      end
      S_START: begin
        oClkDriveLow = 1'b1;
        oDatDriveLow = r_dat_low;
        w_next       = S_SHIFT;
      end
      S_SHIFT: begin
        oDatDriveLow = r_dat_low;
        if (w_fall) begin
          if (r_edge_cnt == 4'd8) w_next = S_STOP;
        end else if (w_tc) begin
          w_next = S_FAIL;
        end
      end
      S_STOP: begin
        oDatDriveLow = r_dat_low;
        if (w_fall)    w_next = S_ACK;
        else if (w_tc) w_next = S_FAIL;
      end
      S_ACK: begin
        if (w_fall)    w_next = r_dat_s2 ? S_FAIL : S_WAIT_IDLE;
        else if (w_tc) w_next = S_FAIL;
      end
      S_WAIT_IDLE: begin
        if (r_clk_s2 && r_dat_s2) w_next = S_OK;
        else if (w_tc)            w_next = S_FAIL;
      end
      S_OK: begin
        oBusy  = 1'b0;
        oDone  = 1'b1;
        w_next = S_IDLE;
      end
      S_FAIL: begin
        oBusy  = 1'b0;
        oError = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shared down-counter: inhibit length, then request timeout, then transfer timeout
  // (reloaded on the first device edge).
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_timer    <= '0;
      r_dat_low  <= 1'b0;
    end else if (w_accept) begin
      r_shift    <= {~^iData, iData};
      r_edge_cnt <= '0;
      r_timer    <= TW'(INHIBIT_CYCLES - 1);
      r_dat_low  <= 1'b0;
    end else begin
      case (r_state)
        S_INHIBIT: begin
          if (!w_tc) r_timer   <= r_timer - 1'b1;
          else       r_dat_low <= 1'b1;
        end
        S_START: r_timer <= TW'(REQ_TIMEOUT - 1);
        S_SHIFT, S_STOP, S_ACK: begin
          if (w_fall) begin
            r_edge_cnt <= r_edge_cnt + 4'd1;
            if (r_edge_cnt == 4'd0) r_timer <= TW'(XFER_TIMEOUT - 1);
            else if (!w_tc)         r_timer <= r_timer - 1'b1;
            if (r_state == S_SHIFT) begin
              r_dat_low <= ~r_shift[0];
              r_shift   <= {1'b0, r_shift[8:1]};
            end else begin
              r_dat_low <= 1'b0;
            end
          end else if (!w_tc) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_WAIT_IDLE: if (!w_tc) r_timer <= r_timer - 1'b1;
        default: r_dat_low <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the host and the
// captured bits are compared with a byte/parity reference; timeouts and reset are covered too.
module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int REQ  = 3000;
  localparam int XFER = 4000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       iReset = 1'b1;
  logic [7:0] iData = 8'h00;
  logic       iSend = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       pin_clk, pin_dat;
  logic       oClkDriveLow, oDatDriveLow, oBusy, oDone, oError;

  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, run = 0, last_run = 0;

  assign pin_clk = ~oClkDriveLow & dev_clk;
  assign pin_dat = ~oDatDriveLow & dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_TIMEOUT(REQ), .XFER_TIMEOUT(XFER)) dut (
    .clk(clk), .iReset(iReset), .iData(iData), .iSend(iSend),
    .iPs2Clk(pin_clk), .iPs2Dat(pin_dat),
    .oClkDriveLow(oClkDriveLow), .oDatDriveLow(oDatDriveLow),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oDone)  done_cnt++;
    if (oError) err_cnt++;
    if (oClkDriveLow) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return (ones % 2 == 0);
  endfunction

  task automatic send_pulse(input logic [7:0] b);
    iData = b;
    iSend = 1'b1;
    cyc(1);
    iSend = 1'b0;
    iData = 8'($urandom);
  endtask

  // Waits for the inhibit/release handshake; ok=0 if it never happens.
  task automatic wait_release(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!oClkDriveLow && n < 50) begin cyc(1); n++; end
    if (!oClkDriveLow) ok = 1'b0;
    n = 0;
    while (oClkDriveLow && n < INH + 50) begin cyc(1); n++; end
    if (oClkDriveLow) ok = 1'b0;
  endtask

  // Device side of one frame: 11 falling edges, samples host data on rising edges 1..10.
  task automatic dev_xfer(input bit ack, output logic [9:0] bits, output logic start_low,
                          output bit ok);
    bits = '0;
    start_low = 1'b0;
    wait_release(ok);
    if (ok) begin
      cyc(HALF);
      start_low = ~pin_dat;
      for (int e = 1; e <= 11; e++) begin
        if (e == 11 && ack) dev_dat = 1'b0;
        dev_clk = 1'b0;
        cyc(HALF);
        dev_clk = 1'b1;
        if (e <= 10) bits[e-1] = pin_dat;
        cyc(HALF);
      end
      dev_dat = 1'b1;
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    cyc(3);
    checks++; if (oClkDriveLow !== 1'b0) begin failures++; $display("FAIL reset_clk got %b want 0", oClkDriveLow); end
    checks++; if (oDatDriveLow !== 1'b0) begin failures++; $display("FAIL reset_dat got %b want 0", oDatDriveLow); end
    checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", oBusy); end
    checks++; if (oDone !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", oDone); end
    checks++; if (oError !== 1'b0) begin failures++; $display("FAIL reset_error got %b want 0", oError); end
    iReset = 1'b0;
    cyc(3);
  endtask

  // One full transfer against the device model; ack=0 means the device withholds ACK.
  task automatic test_send(input logic [7:0] b, input bit ack, input string tag,
                           input bit busy_poke);
    logic [9:0] bits;
    logic       start_low;
    bit         ok;
    int         d0 = done_cnt, e0 = err_cnt, n = 0;
    send_pulse(b);
    checks++; if (oBusy !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept got %b want 1", tag, oBusy); end
    if (busy_poke) begin
      cyc(10);
      iData = 8'h00;
      iSend = 1'b1;
      cyc(1);
      iSend = 1'b0;
    end
    dev_xfer(ack, bits, start_low, ok);
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin cyc(1); n++; end
    cyc(3);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL %s handshake got %b want 1", tag, ok); end
    checks++; if (start_low !== 1'b1) begin failures++; $display("FAIL %s start_bit_low got %b want 1", tag, start_low); end
    checks++; if (last_run != INH + 1) begin failures++; $display("FAIL %s inhibit_len got %0d want %0d", tag, last_run, INH + 1); end
    checks++; if (bits[7:0] !== b) begin failures++; $display("FAIL %s data_bits got %h want %h", tag, bits[7:0], b); end
    checks++; if (bits[8] !== model_parity(b)) begin failures++; $display("FAIL %s parity got %b want %b", tag, bits[8], model_parity(b)); end
    checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL %s stop_bit got %b want 1", tag, bits[9]); end
    checks++; if (done_cnt - d0 != int'(ack)) begin failures++; $display("FAIL %s done_pulses got %0d want %0d", tag, done_cnt - d0, int'(ack)); end
    checks++; if (err_cnt - e0 != int'(!ack)) begin failures++; $display("FAIL %s error_pulses got %0d want %0d", tag, err_cnt - e0, int'(!ack)); end
    checks++; if ({oBusy, oClkDriveLow, oDatDriveLow} !== 3'b000) begin failures++; $display("FAIL %s idle_after got %b want 000", tag, {oBusy, oClkDriveLow, oDatDriveLow}); end
    if (busy_poke) begin
      cyc(INH + 20);
      checks++; if ({oBusy, oClkDriveLow} !== 2'b00) begin failures++; $display("FAIL %s ignored_send got %b want 00", tag, {oBusy, oClkDriveLow}); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0 = done_cnt, n = 0;
    send_pulse(8'hF4);
    wait_release(ok);
    while (!oError && n < REQ + 100) begin cyc(1); n++; end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL timeout handshake got %b want 1", ok); end
    checks++; if (n < REQ || n > REQ + 3) begin failures++; $display("FAIL timeout latency got %0d want %0d..%0d", n, REQ, REQ + 3); end
    cyc(2);
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL timeout done_pulses got %0d want 0", done_cnt - d0); end
    checks++; if ({oBusy, oClkDriveLow, oDatDriveLow} !== 3'b000) begin failures++; $display("FAIL timeout released got %b want 000", {oBusy, oClkDriveLow, oDatDriveLow}); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_pulse(8'h00);
    wait_release(ok);
    cyc(HALF);
    for (int e = 1; e <= 5; e++) begin
      dev_clk = 1'b0; cyc(HALF);
      dev_clk = 1'b1; cyc(HALF);
    end
    checks++; if (oDatDriveLow !== 1'b1) begin failures++; $display("FAIL midreset pre_dat got %b want 1", oDatDriveLow); end
    iReset = 1'b1;
    #1;
    checks++; if ({oClkDriveLow, oDatDriveLow, oBusy} !== 3'b000) begin failures++; $display("FAIL midreset outputs got %b want 000", {oClkDriveLow, oDatDriveLow, oBusy}); end
    cyc(3);
    iReset = 1'b0;
    cyc(3);
    checks++; if (done_cnt != d0 || err_cnt != e0) begin failures++; $display("FAIL midreset pulses got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    test_send(8'hA5, 1'b1, "post_reset", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b = 8'($urandom);
      bit ack = ($urandom_range(0, 3) != 0);
      test_send(b, ack, $sformatf("rand%0d", i), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_send(8'hF4, 1'b1, "send_f4", 1'b0);
    test_send(8'hFF, 1'b1, "send_ff", 1'b0);
    test_send(8'h3C, 1'b0, "no_ack", 1'b0);
    test_timeout();
    test_reset_mid();
    test_send(8'hF4, 1'b1, "busy_ignore", 1'b1);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
